// File: rtl/sample_handshake_pkg.sv
// Shared types and register-map constants for the sample handshake controller.
package sample_handshake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_DIN    = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_DOUT   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ACK    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY    = 1;
  localparam int STAT_RESP    = 2;
  localparam int STAT_TIMEOUT = 3;
  localparam int STAT_OVR_LSB = 8;
  localparam int OVR_W        = 8;

endpackage

// File: rtl/handshake_timeout_timer.sv
// Cycle counter for the WAIT state; flags the last cycle before a filter timeout.
module handshake_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  // Holds at LAST so the count can never wrap back into a non-expired value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sample_handshake_ctrl.sv
// Avalon-MM slave that hands one sample to the filter, waits for its result or a
// timeout, and holds response_out until the CPU acknowledges.
module sample_handshake_ctrl
  import sample_handshake_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              filt_valid,
  output logic [DATA_W-1:0] filt_data,
  input  logic              filt_ready,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              response_out,
  output logic              irq
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [OVR_W-1:0]   ovr_cnt_q, ovr_cnt_d;
  logic               timeout_flag_q, timeout_flag_d;
  logic               irq_en_q, irq_en_d;

  logic wr, wr_ctrl, start, ack, ovr_inc, timer_clr, timer_expired, busy;
  logic unused_wdata;

  assign unused_wdata = ^writedata;

  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr && (address == ADDR_CTRL);
  assign start   = wr_ctrl & writedata[CTRL_START];
  assign ack     = wr_ctrl & writedata[CTRL_ACK];

  assign busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign filt_valid   = (state_q == ST_ISSUE);
  assign filt_data    = din_q;
  assign response_out = (state_q == ST_RESP);
  assign irq          = response_out & irq_en_q;

  handshake_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (timer_clr),
    .en     (state_q == ST_WAIT),
    .expired(timer_expired)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d        = state_q;
    din_d          = din_q;
    dout_d         = dout_q;
    ovr_cnt_d      = ovr_cnt_q;
    timeout_flag_d = timeout_flag_q;
    irq_en_d       = irq_en_q;
    ovr_inc        = 1'b0;
    timer_clr      = 1'b0;

    if (wr_ctrl) irq_en_d = writedata[CTRL_IRQ_EN];
    if (wr && (address == ADDR_DIN) && !busy) din_d = writedata[DATA_W-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        ovr_inc = start;
        if (filt_ready) begin
          state_d   = ST_WAIT;
          timer_clr = 1'b1;
        end
      end
      ST_WAIT: begin
        ovr_inc = start;
        // A result arriving on the expiry cycle takes priority over the timeout.
        if (res_valid) begin
          state_d        = ST_RESP;
          dout_d         = res_data;
          timeout_flag_d = 1'b0;
        end else if (timer_expired) begin
          state_d        = ST_RESP;
          dout_d         = '0;
          timeout_flag_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (ack) state_d = start ? ST_ISSUE : ST_IDLE;
        else     ovr_inc = start;
      end
      default: state_d = ST_IDLE;
    endcase

    if (ovr_inc && (ovr_cnt_q != '1)) ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      din_q          <= '0;
      dout_q         <= '0;
      ovr_cnt_q      <= '0;
      timeout_flag_q <= 1'b0;
      irq_en_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      din_q          <= din_d;
      dout_q         <= dout_d;
      ovr_cnt_q      <= ovr_cnt_d;
      timeout_flag_q <= timeout_flag_d;
      irq_en_q       <= irq_en_d;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DIN:  readdata = 32'(din_q);
      ADDR_CTRL: readdata[CTRL_IRQ_EN] = irq_en_q;
      ADDR_DOUT: readdata = 32'(dout_q);
      ADDR_STATUS: begin
        readdata[STAT_OVR_LSB +: OVR_W] = ovr_cnt_q;
        readdata[STAT_TIMEOUT]          = timeout_flag_q;
        readdata[STAT_RESP]             = response_out;
        readdata[STAT_BUSY]             = busy;
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sample_handshake_ctrl.sv
// Directed bench for sample_handshake_ctrl with an 8-cycle filter timeout.
module tb_sample_handshake_ctrl;

  localparam int DATA_W = 16;
  localparam int TO     = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              filt_valid;
  logic [DATA_W-1:0] filt_data;
  logic              filt_ready;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              response_out;
  logic              irq;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sample_handshake_ctrl #(
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .filt_valid  (filt_valid),
    .filt_data   (filt_data),
    .filt_ready  (filt_ready),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .response_out(response_out),
    .irq         (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    address = addr;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic accept();
    filt_ready = 1'b1;
    step();
    filt_ready = 1'b0;
  endtask

  task automatic result(input logic [DATA_W-1:0] d);
    res_valid = 1'b1;
    res_data  = d;
    step();
    res_valid = 1'b0;
    res_data  = '0;
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    filt_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    step(); step();
    reset = 1'b0;

    // Reset state
    check("rst_resp", 32'(response_out), 32'd0);
    check("rst_fvalid", 32'(filt_valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    read_check("rst_din", 2'd0, 32'h0);
    read_check("rst_ctrl", 2'd1, 32'h0);
    read_check("rst_dout", 2'd2, 32'h0);
    read_check("rst_status", 2'd3, 32'h0);

    // Basic transaction
    bus_write(2'd0, 32'h0000_1234);
    read_check("basic_din", 2'd0, 32'h1234);
    bus_write(2'd1, 32'h1);
    check("basic_fvalid", 32'(filt_valid), 32'd1);
    check("basic_fdata", 32'(filt_data), 32'h1234);
    read_check("basic_busy", 2'd3, 32'h2);
    accept();
    check("basic_fvalid_drop", 32'(filt_valid), 32'd0);
    step(); step();
    check("basic_wait_resp", 32'(response_out), 32'd0);
    result(16'h0ABC);
    check("basic_resp", 32'(response_out), 32'd1);
    check("basic_irq_off", 32'(irq), 32'd0);
    read_check("basic_dout", 2'd2, 32'h0ABC);
    read_check("basic_status", 2'd3, 32'h4);
    bus_write(2'd1, 32'h2);
    check("basic_ack", 32'(response_out), 32'd0);
    read_check("basic_status_idle", 2'd3, 32'h0);

    // Timeout: response rises exactly TO cycles after WAIT entry
    bus_write(2'd1, 32'h1);
    accept();
    for (int i = 1; i < TO; i++) begin
      step();
      check($sformatf("to_wait_%0d", i), 32'(response_out), 32'd0);
    end
    step();
    check("to_resp", 32'(response_out), 32'd1);
    read_check("to_dout", 2'd2, 32'h0);
    read_check("to_status", 2'd3, 32'hC);
    bus_write(2'd1, 32'h2);
    read_check("to_status_after_ack", 2'd3, 32'h8);

    // Race: result on the timeout cycle wins
    bus_write(2'd1, 32'h1);
    accept();
    for (int i = 1; i < TO; i++) step();
    check("race_pre", 32'(response_out), 32'd0);
    result(16'h0055);
    check("race_resp", 32'(response_out), 32'd1);
    read_check("race_dout", 2'd2, 32'h0055);
    read_check("race_status", 2'd3, 32'h4);
    bus_write(2'd1, 32'h2);

    // Overrun during WAIT
    bus_write(2'd0, 32'h1111);
    bus_write(2'd1, 32'h1);
    accept();
    bus_write(2'd1, 32'h1);
    bus_write(2'd1, 32'h1);
    bus_write(2'd1, 32'h1);
    bus_write(2'd0, 32'h2222);
    read_check("ovr_din_kept", 2'd0, 32'h1111);
    read_check("ovr_status_wait", 2'd3, 32'h0302);
    result(16'h0777);
    check("ovr_resp", 32'(response_out), 32'd1);
    read_check("ovr_dout", 2'd2, 32'h0777);
    read_check("ovr_status_resp", 2'd3, 32'h0304);

    // Back-to-back ACK+START with IRQ enabled
    bus_write(2'd0, 32'h3333);
    bus_write(2'd1, 32'h7);
    check("b2b_fvalid", 32'(filt_valid), 32'd1);
    check("b2b_fdata", 32'(filt_data), 32'h3333);
    check("b2b_resp", 32'(response_out), 32'd0);
    check("b2b_irq_low", 32'(irq), 32'd0);
    read_check("b2b_status", 2'd3, 32'h0302);
    read_check("b2b_ctrl", 2'd1, 32'h4);
    accept();
    result(16'h0001);
    check("b2b_resp2", 32'(response_out), 32'd1);
    check("b2b_irq_high", 32'(irq), 32'd1);
    bus_write(2'd1, 32'h6);
    check("b2b_ack_resp", 32'(response_out), 32'd0);
    check("b2b_ack_irq", 32'(irq), 32'd0);

    // Reset mid-WAIT, then a late result
    bus_write(2'd1, 32'h5);
    accept();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    result(16'h0999);
    check("rstw_resp", 32'(response_out), 32'd0);
    check("rstw_fvalid", 32'(filt_valid), 32'd0);
    check("rstw_irq", 32'(irq), 32'd0);
    read_check("rstw_dout", 2'd2, 32'h0);
    read_check("rstw_status", 2'd3, 32'h0);
    read_check("rstw_din", 2'd0, 32'h0);
    read_check("rstw_ctrl", 2'd1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
